// File: rtl/score_tracker.sv
// Memory-game score/lives tracker: BCD score, lives bar, end-of-game blink, mode/status nibble.
// Latency: every output registered, valid one cycle after the causing edge; no backpressure (strobes are consumed every cycle).
module score_tracker #(
   parameter int MAX_SCORE = 32,
   parameter int LIVES     = 10,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       CLOCK_50,
   input  logic       resetn,
   input  logic       ingameOn,
   input  logic       gameOver,
   input  logic       userquit,
   input  logic       match_pulse,
   input  logic       miss_pulse,
   input  logic [3:0] mode,
   output logic [3:0] hex0hldr,
   output logic [3:0] hex4hldr,
   output logic [3:0] hex5hldr,
   output logic [9:0] ledrhldr
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] PLAY = 2'd1;
   localparam logic [1:0] OVER = 2'd2;
   localparam logic [1:0] QUIT = 2'd3;

   localparam int            CW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST   = CW'(BLINK_DIV - 1);
   localparam logic [6:0]    SCORE_MAX  = 7'(MAX_SCORE);
   localparam logic [3:0]    LIVES_INIT = 4'(LIVES);

   logic [1:0]    state, state_n;
   logic [3:0]    tens, tens_n, ones, ones_n, lives, lives_n;
   logic [CW-1:0] blink_cnt, blink_cnt_n;
   logic          blink_on, blink_on_n;
   logic [6:0]    score;
   logic [3:0]    hex0_n, hex4_n, hex5_n;
   logic [9:0]    ledr_n;

   assign score = 7'(tens) * 7'd10 + 7'(ones);

   always_comb begin
      state_n     = state;
      tens_n      = tens;
      ones_n      = ones;
      lives_n     = lives;
      blink_cnt_n = blink_cnt;
      blink_on_n  = blink_on;
      case (state)
         IDLE: begin
            tens_n  = 4'd0;
            ones_n  = 4'd0;
            lives_n = LIVES_INIT;
            if (ingameOn) state_n = PLAY;
         end
         PLAY: begin
            // both strobes land in the same cycle, so a final match still scores
            if (match_pulse && (score < SCORE_MAX)) begin
               if (ones == 4'd9) begin
                  ones_n = 4'd0;
                  tens_n = tens + 4'd1;
               end else begin
                  ones_n = ones + 4'd1;
               end
            end
            if (miss_pulse && (lives != 4'd0)) lives_n = lives - 4'd1;
            if (userquit)            state_n = QUIT;
            else if (gameOver)       state_n = OVER;
            else if (lives_n == 4'd0) state_n = OVER;
         end
         OVER: begin
            if (userquit)       state_n = QUIT;
            else if (!ingameOn) state_n = IDLE;
         end
         default: begin
            if (!userquit && !ingameOn) state_n = IDLE;
         end
      endcase

      // blink phase restarts lit on every entry into OVER
      if (state_n == OVER) begin
         if (state != OVER) begin
            blink_cnt_n = '0;
            blink_on_n  = 1'b1;
         end else if (blink_cnt == CNT_LAST) begin
            blink_cnt_n = '0;
            blink_on_n  = ~blink_on;
         end else begin
            blink_cnt_n = blink_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      hex0_n = mode;
      hex4_n = 4'hF;
      hex5_n = 4'hF;
      ledr_n = 10'h000;
      case (state_n)
         PLAY: begin
            hex4_n = ones_n;
            hex5_n = tens_n;
            ledr_n = ~(10'h3FF << lives_n);
         end
         OVER: begin
            hex0_n = 4'hE;
            hex4_n = ones_n;
            hex5_n = tens_n;
            ledr_n = blink_on_n ? 10'h3FF : 10'h000;
         end
         QUIT:    hex0_n = 4'hF;
         default: hex0_n = mode;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         tens      <= 4'd0;
         ones      <= 4'd0;
         lives     <= LIVES_INIT;
         blink_cnt <= '0;
         blink_on  <= 1'b0;
         hex0hldr  <= 4'hF;
         hex4hldr  <= 4'hF;
         hex5hldr  <= 4'hF;
         ledrhldr  <= 10'h000;
      end else begin
         state     <= state_n;
         tens      <= tens_n;
         ones      <= ones_n;
         lives     <= lives_n;
         blink_cnt <= blink_cnt_n;
         blink_on  <= blink_on_n;
         hex0hldr  <= hex0_n;
         hex4hldr  <= hex4_n;
         hex5hldr  <= hex5_n;
         ledrhldr  <= ledr_n;
      end
   end

endmodule

// File: tb/tb_score_tracker.sv
// Bench for score_tracker: directed vector table, corner-case sequences, then random play against a reference model.
module tb_score_tracker;

   localparam int MAXS   = 32;
   localparam int NLIVES = 10;
   localparam int BDIV   = 4;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       ig = 1'b0, go = 1'b0, uq = 1'b0, mt = 1'b0, ms = 1'b0;
   logic [3:0] md = 4'h0;
   logic [3:0] h0, h4, h5;
   logic [9:0] ledr;

   int checks = 0;
   int errors = 0;

   score_tracker #(.MAX_SCORE(MAXS), .LIVES(NLIVES), .BLINK_DIV(BDIV)) dut (
      .CLOCK_50(clk), .resetn(resetn), .ingameOn(ig), .gameOver(go), .userquit(uq),
      .match_pulse(mt), .miss_pulse(ms), .mode(md),
      .hex0hldr(h0), .hex4hldr(h4), .hex5hldr(h5), .ledrhldr(ledr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       ig, go, uq, mt, ms;
      logic [3:0] md;
      logic [3:0] h0, h4, h5;
      logic [9:0] ledr;
   } vec_t;

   // reference model: game state, integer score, lives count, cycles spent in OVER
   typedef enum int {M_IDLE, M_PLAY, M_OVER, M_QUIT} mst_t;
   mst_t       m_st;
   int         m_score, m_lives, m_over;
   logic [3:0] m_mode;
   bit         m_in_rst;

   task automatic model_reset();
      m_st = M_IDLE; m_score = 0; m_lives = NLIVES; m_over = 0; m_in_rst = 1'b1; m_mode = 4'h0;
   endtask

   task automatic model_step();
      mst_t prev;
      prev = m_st;
      m_in_rst = 1'b0;
      case (m_st)
         M_IDLE: begin
            m_score = 0; m_lives = NLIVES;
            if (ig) m_st = M_PLAY;
         end
         M_PLAY: begin
            if (mt && m_score < MAXS) m_score++;
            if (ms && m_lives > 0) m_lives--;
            if (uq) m_st = M_QUIT;
            else if (go) m_st = M_OVER;
            else if (m_lives == 0) m_st = M_OVER;
         end
         M_OVER: begin
            if (uq) m_st = M_QUIT;
            else if (!ig) m_st = M_IDLE;
         end
         default: if (!uq && !ig) m_st = M_IDLE;
      endcase
      if (m_st == M_OVER) m_over = (prev == M_OVER) ? m_over + 1 : 0;
      m_mode = md;
   endtask

   function automatic logic [21:0] model_out();
      logic [3:0] e0, e4, e5;
      logic [9:0] el;
      e0 = m_mode; e4 = 4'hF; e5 = 4'hF; el = 10'h000;
      if (m_in_rst) e0 = 4'hF;
      else case (m_st)
         M_PLAY: begin
            e4 = 4'(m_score % 10); e5 = 4'(m_score / 10);
            el = 10'((1 << m_lives) - 1);
         end
         M_OVER: begin
            e0 = 4'hE;
            e4 = 4'(m_score % 10); e5 = 4'(m_score / 10);
            el = (((m_over / BDIV) % 2) == 0) ? 10'h3FF : 10'h000;
         end
         M_QUIT:  e0 = 4'hF;
         default: e0 = m_mode;
      endcase
      return {e0, e4, e5, el};
   endfunction

   task automatic check(input string name, input logic [3:0] e0, input logic [3:0] e4,
                        input logic [3:0] e5, input logic [9:0] el);
      checks++;
      if ({h0, h4, h5, ledr} !== {e0, e4, e5, el}) begin
         errors++;
         $display("FAIL %s: got hex0=%h hex4=%h hex5=%h ledr=%h, expected hex0=%h hex4=%h hex5=%h ledr=%h",
                  name, h0, h4, h5, ledr, e0, e4, e5, el);
      end
   endtask

   task automatic check_model(input string name);
      logic [21:0] e;
      e = model_out();
      check(name, e[21:18], e[17:14], e[13:10], e[9:0]);
   endtask

   task automatic tick();
      @(posedge clk);
      if (!resetn) model_reset();
      else model_step();
      @(negedge clk);
   endtask

   task automatic set_in(input bit i, input bit g, input bit u, input bit a, input bit b, input logic [3:0] m);
      ig = i; go = g; uq = u; mt = a; ms = b; md = m;
   endtask

   task automatic do_reset();
      set_in(0, 0, 0, 0, 0, md);
      resetn = 1'b0;
      model_reset();
      tick();
      resetn = 1'b1;
   endtask

   initial begin
      vec_t tbl[$];
      model_reset();
      tick();
      check("reset_state", 4'hF, 4'hF, 4'hF, 10'h000);
      resetn = 1'b1;

      //              ig    go    uq    mt    ms    mode   hex0   hex4   hex5   ledr
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h5, 4'h5, 4'hF, 4'hF, 10'h000});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h5, 4'h5, 4'hF, 4'hF, 10'h000});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 4'h5, 4'h0, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h5, 4'h5, 4'h1, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h6, 4'h6, 4'h1, 4'h0, 10'h1FF});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 4'h6, 4'h2, 4'h0, 10'h0FF});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 4'hE, 4'h2, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 4'hE, 4'h2, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'hE, 4'h2, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'hE, 4'h2, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'hE, 4'h2, 4'h0, 10'h000});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h6, 4'hF, 4'hF, 10'h000});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'h6, 4'h0, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6, 4'hF, 4'hF, 4'hF, 10'h000});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'hF, 4'hF, 4'hF, 10'h000});
      tbl.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h6, 4'hF, 4'hF, 4'hF, 10'h000});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h3, 4'hF, 4'hF, 10'h000});
      tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h3, 4'h0, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h3, 4'hE, 4'h0, 4'h0, 10'h3FF});
      tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h3, 4'hF, 4'hF, 4'hF, 10'h000});
      tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h3, 4'h3, 4'hF, 4'hF, 10'h000});

      for (int i = 0; i < $size(tbl); i++) begin
         set_in(tbl[i].ig, tbl[i].go, tbl[i].uq, tbl[i].mt, tbl[i].ms, tbl[i].md);
         tick();
         check($sformatf("vec%0d", i), tbl[i].h0, tbl[i].h4, tbl[i].h5, tbl[i].ledr);
      end

      // ten matches, then saturation at MAX_SCORE
      do_reset();
      set_in(1, 0, 0, 0, 0, 4'h2); tick();
      for (int i = 0; i < 10; i++) begin set_in(1, 0, 0, 1, 0, 4'h2); tick(); end
      check("score_10", 4'h2, 4'h0, 4'h1, 10'h3FF);
      for (int i = 0; i < 30; i++) begin set_in(1, 0, 0, 1, 0, 4'h2); tick(); end
      check("score_sat", 4'h2, 4'h2, 4'h3, 10'h3FF);
      set_in(1, 0, 0, 0, 0, 4'h2);
      for (int i = 0; i < 3; i++) tick();
      check("score_sat_hold", 4'h2, 4'h2, 4'h3, 10'h3FF);

      // lives drain one by one, then OVER blinks while score stays frozen
      for (int k = 1; k <= 9; k++) begin
         set_in(1, 0, 0, 0, 1, 4'h2); tick();
         check($sformatf("lives_%0d", 10 - k), 4'h2, 4'h2, 4'h3, 10'((1 << (10 - k)) - 1));
      end
      set_in(1, 0, 0, 0, 1, 4'h2); tick();
      check("over_entry", 4'hE, 4'h2, 4'h3, 10'h3FF);
      for (int j = 1; j < 16; j++) begin
         set_in(1, 0, 0, 1, 1, 4'h2); tick();
         check($sformatf("blink_%0d", j), 4'hE, 4'h2, 4'h3, (((j / BDIV) % 2) == 0) ? 10'h3FF : 10'h000);
      end

      // last life lost in the same cycle as the 9->10 match
      do_reset();
      set_in(1, 0, 0, 0, 0, 4'h7); tick();
      for (int i = 0; i < 9; i++) begin set_in(1, 0, 0, 1, 0, 4'h7); tick(); end
      for (int i = 0; i < 9; i++) begin set_in(1, 0, 0, 0, 1, 4'h7); tick(); end
      check("pre_both", 4'h7, 4'h9, 4'h0, 10'h001);
      set_in(1, 0, 0, 1, 1, 4'h7); tick();
      check("both_pulses", 4'hE, 4'h0, 4'h1, 10'h3FF);
      set_in(1, 0, 0, 1, 0, 4'h7); tick();
      check("over_frozen", 4'hE, 4'h0, 4'h1, 10'h3FF);

      // asynchronous reset mid-game at score 17
      do_reset();
      set_in(1, 0, 0, 0, 0, 4'h4); tick();
      for (int i = 0; i < 17; i++) begin set_in(1, 0, 0, 1, 0, 4'h4); tick(); end
      check("score_17", 4'h4, 4'h7, 4'h1, 10'h3FF);
      #2;
      resetn = 1'b0;
      model_reset();
      #1;
      check("async_reset", 4'hF, 4'hF, 4'hF, 10'h000);
      tick();
      resetn = 1'b1;
      set_in(1, 0, 0, 0, 0, 4'h4); tick();
      check("restart_00", 4'h4, 4'h0, 4'h0, 10'h3FF);

      // randomized play against the model
      for (int n = 0; n < 3000; n++) begin
         resetn = ($urandom_range(0, 399) != 0);
         set_in($urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 4, $urandom_range(0, 9) < 1, 4'($urandom_range(0, 15)));
         tick();
         check_model($sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_tracker.md
SCORE_TRACKER -- requirements
Module: score_tracker

Interface
REQ-001 Parameter MAX_SCORE, default 32: saturation value of the decimal score (range 1..99).
REQ-002 Parameter LIVES, default 10: starting lives (range 1..10).
REQ-003 Parameter BLINK_DIV, default 25000000: cycles per LEDR blink phase (0.5 s at 50 MHz).
REQ-004 CLOCK_50  input  1  sole clock; all state changes on its rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 ingameOn  input  1  level; game session active.
REQ-007 gameOver  input  1  level; external end-of-game request.
REQ-008 userquit  input  1  level; player abort.
REQ-009 match_pulse  input  1  one-cycle strobe; tile pair matched.
REQ-010 miss_pulse  input  1  one-cycle strobe; wrong pair.
REQ-011 mode  input  4  game mode code shown on hex0hldr.
REQ-012 hex0hldr  output  4  mode/status nibble to display.
REQ-013 hex4hldr  output  4  score ones digit, BCD.
REQ-014 hex5hldr  output  4  score tens digit, BCD.
REQ-015 ledrhldr  output  10  lives bar / blink pattern.

Function
REQ-016 All outputs SHALL be registered; each reflects state one cycle after the causing input edge.
REQ-017 FSM states SHALL be IDLE, PLAY, OVER, QUIT.
REQ-018 IDLE: score cleared to 00, lives = LIVES; go to PLAY when ingameOn=1.
REQ-019 Transition priority from PLAY SHALL be userquit (-> QUIT) > gameOver (-> OVER) > lives reaching 0 (-> OVER).
REQ-020 PLAY: match_pulse increments score in BCD; ones 9 -> 0 with tens +1.
REQ-021 Score SHALL saturate at MAX_SCORE; further match_pulse ignored.
REQ-022 PLAY: miss_pulse decrements lives; at lives 0, go to OVER next cycle; lives never wraps below 0.
REQ-023 Simultaneous match_pulse and miss_pulse: both applied in the same cycle; the increment counts even if the miss ends the game.
REQ-024 Pulses outside PLAY SHALL be ignored.
REQ-025 ledrhldr in PLAY = thermometer of lives: bits [lives-1:0] set, others clear.
REQ-026 OVER: score frozen; ledrhldr toggles between 10'h3FF and 10'h000 every BLINK_DIV cycles, starting 10'h3FF on entry; blink counter cleared on entry.
REQ-027 OVER -> IDLE when ingameOn=0; userquit in OVER -> QUIT.
REQ-028 QUIT: hex4hldr=hex5hldr=4'hF (blank), ledrhldr=0; -> IDLE when userquit=0 and ingameOn=0.
REQ-029 hex0hldr = mode in IDLE/PLAY, 4'hE in OVER, 4'hF in QUIT.
REQ-030 hex4hldr/hex5hldr in IDLE SHALL be 4'hF; in PLAY/OVER show score digits, tens digit showing 0 (not blank) when score < 10.
REQ-031 hex digits SHALL never hold 4'hA..4'hE in PLAY/OVER.

Reset
REQ-032 resetn=0 SHALL immediately force state IDLE, score 00, lives LIVES, blink counter 0, hex0hldr=mode register 4'hF, hex4hldr=hex5hldr=4'hF, ledrhldr=0.
REQ-033 Reset mid-game SHALL discard score and lives; after release, behaviour is IDLE.

Verification
REQ-034 Reset, ingameOn=1, 10 match_pulse -> hex5hldr=1, hex4hldr=0, ledrhldr=10'h3FF.
REQ-035 In PLAY, 40 match_pulse (MAX_SCORE=32) -> hex5hldr=3, hex4hldr=2, stays.
REQ-036 10 miss_pulse -> ledrhldr steps 10'h1FF..10'h001, then OVER: hex0hldr=4'hE, LEDR blinks 3FF/000 with period 2*BLINK_DIV (BLINK_DIV=4 in sim).
REQ-037 Score 9, match_pulse and miss_pulse same cycle at lives 1 -> score 10 frozen, state OVER.
REQ-038 In PLAY, userquit=1 and gameOver=1 same cycle -> QUIT: hex4/5=4'hF, hex0=4'hF, ledrhldr=0.
REQ-039 resetn pulsed low mid-PLAY at score 17 -> outputs at reset values without clock edge; next ingameOn starts at 00.
